// File: rtl/gate_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_chk_pkg
// Purpose  : Shared types, mask bit positions and golden gate function for
//            the gate stimulus checker.
// Revision : 1.0 - initial release
// ============================================================================
package gate_chk_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int c_bit_and  = 6;
    localparam int c_bit_or   = 5;
    localparam int c_bit_not  = 4;
    localparam int c_bit_nand = 3;
    localparam int c_bit_nor  = 2;
    localparam int c_bit_xor  = 1;
    localparam int c_bit_xnor = 0;

    function automatic logic [6:0] gate_expected(input logic a, input logic b);
        logic [6:0] e;
        e             = '0;
        e[c_bit_and]  = a & b;
        e[c_bit_or]   = a | b;
        e[c_bit_not]  = ~a;
        e[c_bit_nand] = ~(a & b);
        e[c_bit_nor]  = ~(a | b);
        e[c_bit_xor]  = a ^ b;
        e[c_bit_xnor] = ~(a ^ b);
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_ref_model.sv
`default_nettype none
// ============================================================================
// Module   : gate_ref_model
// Purpose  : Combinational golden model mapping {a,b} to the 7 gate outputs.
// Revision : 1.0 - initial release
// ============================================================================
module gate_ref_model
    import gate_chk_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    output logic [6:0] o_expected
);

    assign o_expected = gate_expected(i_a, i_b);

endmodule
`default_nettype wire

// File: rtl/gate_stim_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_stim_checker
// Purpose  : BIST harness sweeping a two-input gate block and checking its
//            seven outputs against a golden model.
// Revision : 1.0 - initial release
// ============================================================================
module gate_stim_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYC = 1,
    parameter int NUM_PASSES = 1,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             and_gate,
    input  logic             or_gate,
    input  logic             not_gate,
    input  logic             nand_gate,
    input  logic             nor_gate,
    input  logic             xor_gate,
    input  logic             xnor_gate,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_err_vec,
    output logic [6:0]       first_err_mask
);

    localparam logic [ERR_W-1:0] c_err_max   = '1;
    localparam logic [7:0]       c_last_pass = 8'(NUM_PASSES - 1);
    localparam logic [3:0]       c_settle_ld = 4'(SETTLE_CYC - 1);

    state_t           r_state;
    logic [1:0]       r_vec;
    logic [7:0]       r_pass_cnt;
    logic [3:0]       r_settle;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err_count;
    logic [1:0]       r_first_vec;
    logic [6:0]       r_first_mask;

    logic [6:0]       w_expected;
    logic [6:0]       w_actual;
    logic [6:0]       w_diff;
    logic             w_mismatch;
    logic             w_last;

    gate_ref_model u_ref (
        .i_a        (r_vec[1]),
        .i_b        (r_vec[0]),
        .o_expected (w_expected)
    );

    assign w_actual   = {and_gate, or_gate, not_gate, nand_gate, nor_gate, xor_gate, xnor_gate};
    assign w_diff     = w_actual ^ w_expected;
    assign w_mismatch = |w_diff;
    assign w_last     = (r_vec == 2'd3) && (r_pass_cnt == c_last_pass);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_vec        <= '0;
            r_pass_cnt   <= '0;
            r_settle     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_first_vec  <= '0;
            r_first_mask <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vec        <= '0;
                        r_pass_cnt   <= '0;
                        r_err_count  <= '0;
                        r_first_vec  <= '0;
                        r_first_mask <= '0;
                        r_pass       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    r_settle <= c_settle_ld;
                    r_state  <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle == 4'd0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    // err_count never returns to zero within a run, so zero marks "no failure yet"
                    if (w_mismatch) begin
                        if (r_err_count != c_err_max) begin
                            r_err_count <= r_err_count + 1'b1;
                        end
                        if (r_err_count == '0) begin
                            r_first_vec  <= r_vec;
                            r_first_mask <= w_diff;
                        end
                    end
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_pass  <= !w_mismatch && (r_err_count == '0);
                        r_state <= S_DONE;
                    end else begin
                        if (r_vec == 2'd3) begin
                            r_pass_cnt <= r_pass_cnt + 8'd1;
                        end
                        r_vec   <= r_vec + 2'd1;
                        r_state <= S_DRIVE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a              = r_vec[1];
    assign b              = r_vec[0];
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err_count;
    assign first_err_vec  = r_first_vec;
    assign first_err_mask = r_first_mask;

endmodule
`default_nettype wire

// File: tb/tb_gate_stim_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_stim_checker
// Purpose  : Directed, table-driven bench for gate_stim_checker with a
//            fault-injectable gate block per instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_stim_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_s[3], b_s[3], start_s[3], busy_s[3], done_s[3], pass_s[3];
    logic       g_and[3], g_or[3], g_not[3], g_nand[3], g_nor[3], g_xor[3], g_xnor[3];
    logic [7:0] err0, err1;
    logic [1:0] err2;
    logic [1:0] fvec_s[3];
    logic [6:0] fmask_s[3];
    int         fault[3];

    int n_cmp = 0;
    int n_bad = 0;

    // Gate block under observation: 0 good, 1 xor stuck 0, 2 and inverted, 3 xnor stuck 1
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            g_and[k]  = a_s[k] & b_s[k];
            g_or[k]   = a_s[k] | b_s[k];
            g_not[k]  = ~a_s[k];
            g_nand[k] = ~(a_s[k] & b_s[k]);
            g_nor[k]  = ~(a_s[k] | b_s[k]);
            g_xor[k]  = a_s[k] ^ b_s[k];
            g_xnor[k] = ~(a_s[k] ^ b_s[k]);
            if (fault[k] == 1) g_xor[k]  = 1'b0;
            if (fault[k] == 2) g_and[k]  = ~(a_s[k] & b_s[k]);
            if (fault[k] == 3) g_xnor[k] = 1'b1;
        end
    end

    gate_stim_checker u0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]),
        .and_gate(g_and[0]), .or_gate(g_or[0]), .not_gate(g_not[0]), .nand_gate(g_nand[0]),
        .nor_gate(g_nor[0]), .xor_gate(g_xor[0]), .xnor_gate(g_xnor[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err0),
        .first_err_vec(fvec_s[0]), .first_err_mask(fmask_s[0])
    );

    gate_stim_checker #(.SETTLE_CYC(3), .NUM_PASSES(2)) u1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]),
        .and_gate(g_and[1]), .or_gate(g_or[1]), .not_gate(g_not[1]), .nand_gate(g_nand[1]),
        .nor_gate(g_nor[1]), .xor_gate(g_xor[1]), .xnor_gate(g_xnor[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err1),
        .first_err_vec(fvec_s[1]), .first_err_mask(fmask_s[1])
    );

    gate_stim_checker #(.ERR_W(2), .NUM_PASSES(2)) u2 (
        .clk(clk), .rst(rst), .start(start_s[2]), .a(a_s[2]), .b(b_s[2]),
        .and_gate(g_and[2]), .or_gate(g_or[2]), .not_gate(g_not[2]), .nand_gate(g_nand[2]),
        .nor_gate(g_nor[2]), .xor_gate(g_xor[2]), .xnor_gate(g_xnor[2]),
        .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .err_count(err2),
        .first_err_vec(fvec_s[2]), .first_err_mask(fmask_s[2])
    );

    function automatic logic [7:0] errv(input int k);
        case (k)
            0:       return err0;
            1:       return err1;
            default: return {6'd0, err2};
        endcase
    endfunction

    function automatic logic [20:0] all_out(input int k);
        return {a_s[k], b_s[k], busy_s[k], done_s[k], pass_s[k], errv(k), fvec_s[k], fmask_s[k]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Waits (bounded) for done; n = edges after the reference edge
    task automatic wait_done(input int k, output int n, output logic [31:0] walk, output int nwalk);
        logic [1:0] prev;
        prev  = {a_s[k], b_s[k]};
        walk  = {30'd0, prev};
        nwalk = 1;
        n     = 0;
        while (!done_s[k] && n < 400) begin
            @(posedge clk); #1;
            n++;
            if ({a_s[k], b_s[k]} != prev) begin
                prev  = {a_s[k], b_s[k]};
                walk  = {walk[29:0], prev};
                nwalk++;
            end
        end
    endtask

    task automatic run(input int k, output int n, output logic [31:0] walk, output int nwalk);
        start_s[k] = 1'b1;
        @(posedge clk); #1;
        start_s[k] = 1'b0;
        chk($sformatf("u%0d busy@accept", k), 32'(busy_s[k]), 32'd1);
        chk($sformatf("u%0d pass/err cleared@accept", k), {23'd0, pass_s[k], errv(k)}, 32'd0);
        wait_done(k, n, walk, nwalk);
    endtask

    typedef struct {
        int          inst;
        int          flt;
        int          edges;
        logic [7:0]  err;
        logic [1:0]  fvec;
        logic [6:0]  fmask;
        logic        pass;
        logic [31:0] walk;
        int          nwalk;
    } vec_t;

    vec_t        tbl[8];
    int          n, nw;
    logic [31:0] walk;
    int          dones;

    initial begin
        tbl[0] = '{0, 0, 12, 8'd0, 2'b00, 7'b0000000, 1'b1, 32'h1B,   4};
        tbl[1] = '{0, 1, 12, 8'd2, 2'b01, 7'b0000010, 1'b0, 32'h1B,   4};
        tbl[2] = '{0, 2, 12, 8'd4, 2'b00, 7'b1000000, 1'b0, 32'h1B,   4};
        tbl[3] = '{0, 3, 12, 8'd2, 2'b01, 7'b0000001, 1'b0, 32'h1B,   4};
        tbl[4] = '{1, 0, 40, 8'd0, 2'b00, 7'b0000000, 1'b1, 32'h1B1B, 8};
        tbl[5] = '{1, 1, 40, 8'd4, 2'b01, 7'b0000010, 1'b0, 32'h1B1B, 8};
        tbl[6] = '{2, 2, 24, 8'd3, 2'b00, 7'b1000000, 1'b0, 32'h1B1B, 8};
        tbl[7] = '{2, 0, 24, 8'd0, 2'b00, 7'b0000000, 1'b1, 32'h1B1B, 8};

        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0;
            fault[k]   = 0;
        end
        rst = 1'b1;
        #12;
        for (int k = 0; k < 3; k++) chk($sformatf("u%0d reset outputs", k), 32'(all_out(k)), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            fault[tbl[i].inst] = tbl[i].flt;
            run(tbl[i].inst, n, walk, nw);
            chk($sformatf("t%0d latency", i), 32'(n), 32'(tbl[i].edges));
            chk($sformatf("t%0d walk", i), walk, tbl[i].walk);
            chk($sformatf("t%0d walk len", i), 32'(nw), 32'(tbl[i].nwalk));
            chk($sformatf("t%0d err_count", i), 32'(errv(tbl[i].inst)), 32'(tbl[i].err));
            chk($sformatf("t%0d first_err", i), {23'd0, fvec_s[tbl[i].inst], fmask_s[tbl[i].inst]},
                {23'd0, tbl[i].fvec, tbl[i].fmask});
            chk($sformatf("t%0d pass", i), 32'(pass_s[tbl[i].inst]), 32'(tbl[i].pass));
            @(posedge clk); #1;
            chk($sformatf("t%0d done/busy after DONE", i), {30'd0, done_s[tbl[i].inst], busy_s[tbl[i].inst]}, 32'd0);
            chk($sformatf("t%0d pass held", i), 32'(pass_s[tbl[i].inst]), 32'(tbl[i].pass));
            @(negedge clk);
            fault[tbl[i].inst] = 0;
        end

        // Async reset during SETTLE of vector 10 on u1 (after a mismatch at 01)
        fault[1]   = 1;
        start_s[1] = 1'b1;
        @(posedge clk); #1;
        start_s[1] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("rst-mid: a/b before reset", {30'd0, a_s[1], b_s[1]}, 32'd2);
        chk("rst-mid: err before reset", 32'(err1), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst-mid: outputs cleared at once", 32'(all_out(1)), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        fault[1] = 0;
        dones    = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done_s[1]) dones++;
        end
        chk("rst-mid: no done after reset", 32'(dones), 32'd0);
        @(negedge clk);
        run(1, n, walk, nw);
        chk("rst-mid: rerun latency", 32'(n), 32'd40);
        chk("rst-mid: rerun pass", {23'd0, pass_s[1], err1}, 32'h100);
        @(negedge clk);
        @(negedge clk);

        // start held high on u0: one run, re-accept the edge after DONE->IDLE
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        chk("hold: busy@accept", 32'(busy_s[0]), 32'd1);
        wait_done(0, n, walk, nw);
        chk("hold: first run latency", 32'(n), 32'd12);
        @(posedge clk); #1;
        chk("hold: busy/done low in IDLE", {30'd0, busy_s[0], done_s[0]}, 32'd0);
        @(posedge clk); #1;
        chk("hold: re-accepted", 32'(busy_s[0]), 32'd1);
        start_s[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_done(0, n, walk, nw);
        chk("hold: mid-run start ignored latency", 32'(n + 4), 32'd12);
        chk("hold: second run pass", {23'd0, pass_s[0], err0}, 32'h100);
        @(posedge clk); #1;
        chk("hold: idle after second run", {30'd0, busy_s[0], done_s[0]}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
